// File: rtl/pipeline_hazard_ctrl.sv
// Front-end stall/kill sequencer: structural hazard stalls in RUN, and
// branch-mispredict recovery as redirect -> flush (RECOVER) -> drain (DRAIN).
module pipeline_hazard_ctrl #(
  parameter int ADDR_LEN      = 32,
  parameter int FLUSH_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 255,
  parameter int PERF_W        = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                dp_valid_i,
  input  logic                rrf_allocatable_i,
  input  logic                rob_full_i,
  input  logic                rob_empty_i,
  input  logic                dp_req_alu_i,
  input  logic                dp_req_mem_i,
  input  logic                rs_alu_full_i,
  input  logic                rs_mem_full_i,
  input  logic                br_resolve_i,
  input  logic                br_mispredict_i,
  input  logic [ADDR_LEN-1:0] br_target_i,
  output logic                stall_if_o,
  output logic                stall_id_o,
  output logic                stall_dp_o,
  output logic                kill_if_o,
  output logic                kill_id_o,
  output logic                kill_dp_o,
  output logic                redirect_valid_o,
  output logic [ADDR_LEN-1:0] redirect_pc_o,
  output logic                flush_backend_o,
  output logic [1:0]          state_o,
  output logic                drain_timeout_o,
  output logic [PERF_W-1:0]   stall_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_RECOVER = 2'b01,
    ST_DRAIN   = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

  state_t                state_q;
  logic [FW-1:0]         flush_cnt_q;
  logic [DW-1:0]         drain_cnt_q;
  logic                  redirect_valid_q;
  logic [ADDR_LEN-1:0]   redirect_pc_q;
  logic                  drain_timeout_q;
  logic [PERF_W-1:0]     stall_cnt_q;

  logic hz;
  logic mispredict;
  logic stall_any;
  logic kill_any;

  assign hz = dp_valid_i & (~rrf_allocatable_i | rob_full_i |
                            (dp_req_alu_i & rs_alu_full_i) |
                            (dp_req_mem_i & rs_mem_full_i));

  assign mispredict = br_resolve_i & br_mispredict_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q          <= ST_RUN;
      flush_cnt_q      <= '0;
      drain_cnt_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      drain_timeout_q  <= 1'b0;
      stall_cnt_q      <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (hz && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
          if (mispredict) begin
            state_q          <= ST_RECOVER;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= br_target_i;
            flush_cnt_q      <= FW'(FLUSH_CYCLES - 1);
          end
        end
        ST_RECOVER: begin
          if (flush_cnt_q == '0) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        ST_DRAIN: begin
          drain_cnt_q <= drain_cnt_q + 1'b1;
          // drain_cnt_q counts completed DRAIN cycles, so the current one is number drain_cnt_q+1
          if (rob_empty_i) begin
            state_q <= ST_RUN;
          end else if (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1)) begin
            drain_timeout_q <= 1'b1;
            state_q         <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Hazard stall is only meaningful in RUN; gating with reset keeps all outputs low while in reset.
  assign stall_any = reset_i & (((state_q == ST_RUN) & hz) | (state_q == ST_DRAIN));
  assign kill_any  = (state_q == ST_RECOVER);

  assign stall_if_o       = stall_any;
  assign stall_id_o       = stall_any;
  assign stall_dp_o       = stall_any;
  assign kill_if_o        = kill_any;
  assign kill_id_o        = kill_any;
  assign kill_dp_o        = kill_any;
  assign flush_backend_o  = kill_any;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign state_o          = state_q;
  assign drain_timeout_o  = drain_timeout_q;
  assign stall_cycles_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver pushes expected outputs
// from a cycle-level reference model, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int AL = 32;
  localparam int FC = 2;
  localparam int DT = 255;
  localparam int PW = 8;

  typedef struct packed {
    logic          dp_valid;
    logic          rrf_alloc;
    logic          rob_full;
    logic          rob_empty;
    logic          req_alu;
    logic          req_mem;
    logic          alu_full;
    logic          mem_full;
    logic          br_resolve;
    logic          br_mis;
    logic [AL-1:0] target;
  } in_t;

  typedef struct packed {
    logic [1:0]    state;
    logic [2:0]    stall;
    logic [2:0]    kill;
    logic          redirect_valid;
    logic [AL-1:0] redirect_pc;
    logic          flush;
    logic          timeout;
    logic [PW-1:0] stall_cycles;
  } out_t;

  localparam int OW = $bits(out_t);

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          dp_valid_i = 1'b0, rrf_allocatable_i = 1'b1, rob_full_i = 1'b0;
  logic          rob_empty_i = 1'b1, dp_req_alu_i = 1'b0, dp_req_mem_i = 1'b0;
  logic          rs_alu_full_i = 1'b0, rs_mem_full_i = 1'b0;
  logic          br_resolve_i = 1'b0, br_mispredict_i = 1'b0;
  logic [AL-1:0] br_target_i = '0;
  logic          stall_if_o, stall_id_o, stall_dp_o, kill_if_o, kill_id_o, kill_dp_o;
  logic          redirect_valid_o, flush_backend_o, drain_timeout_o;
  logic [AL-1:0] redirect_pc_o;
  logic [1:0]    state_o;
  logic [PW-1:0] stall_cycles_o;

  pipeline_hazard_ctrl #(
    .ADDR_LEN(AL), .FLUSH_CYCLES(FC), .DRAIN_TIMEOUT(DT), .PERF_W(PW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .dp_valid_i(dp_valid_i), .rrf_allocatable_i(rrf_allocatable_i),
    .rob_full_i(rob_full_i), .rob_empty_i(rob_empty_i),
    .dp_req_alu_i(dp_req_alu_i), .dp_req_mem_i(dp_req_mem_i),
    .rs_alu_full_i(rs_alu_full_i), .rs_mem_full_i(rs_mem_full_i),
    .br_resolve_i(br_resolve_i), .br_mispredict_i(br_mispredict_i),
    .br_target_i(br_target_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_dp_o(stall_dp_o),
    .kill_if_o(kill_if_o), .kill_id_o(kill_id_o), .kill_dp_o(kill_dp_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .flush_backend_o(flush_backend_o), .state_o(state_o),
    .drain_timeout_o(drain_timeout_o), .stall_cycles_o(stall_cycles_o)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // scoreboard state
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: mode 0 RUN, 1 RECOVER, 2 DRAIN
  int          m_mode = 0;
  int          m_flush_left = 0;
  int          m_drain_done = 0;
  bit          m_redirect = 0;
  bit [AL-1:0] m_pc = '0;
  bit          m_timeout = 0;
  int          m_stalls = 0;

  task automatic model_step(input logic rst, input in_t v, output out_t e);
    bit hz;
    int stall_max;
    stall_max = (1 << PW) - 1;
    e = '0;
    if (!rst) begin
      m_mode = 0; m_flush_left = 0; m_drain_done = 0;
      m_redirect = 0; m_pc = '0; m_timeout = 0; m_stalls = 0;
      return;
    end
    hz = v.dp_valid && (!v.rrf_alloc || v.rob_full || (v.req_alu && v.alu_full) ||
                        (v.req_mem && v.mem_full));
    e.state          = 2'(m_mode);
    e.stall          = ((m_mode == 0 && hz) || m_mode == 2) ? 3'b111 : 3'b000;
    e.kill           = (m_mode == 1) ? 3'b111 : 3'b000;
    e.flush          = (m_mode == 1);
    e.redirect_valid = m_redirect;
    e.redirect_pc    = m_pc;
    e.timeout        = m_timeout;
    e.stall_cycles   = PW'(m_stalls);
    m_redirect = 0;
    if (m_mode == 0) begin
      if (hz && m_stalls < stall_max) m_stalls++;
      if (v.br_resolve && v.br_mis) begin
        m_mode = 1; m_flush_left = FC; m_redirect = 1; m_pc = v.target;
      end
    end else if (m_mode == 1) begin
      m_flush_left--;
      if (m_flush_left == 0) begin
        m_mode = 2; m_drain_done = 0;
      end
    end else begin
      m_drain_done++;
      if (v.rob_empty) m_mode = 0;
      else if (m_drain_done == DT) begin
        m_timeout = 1; m_mode = 0;
      end
    end
  endtask

  // driver tasks
  function automatic in_t idle_in();
    in_t v;
    v = '0;
    v.rrf_alloc = 1'b1;
    v.rob_empty = 1'b1;
    return v;
  endfunction

  function automatic in_t rand_in(input int mis_pct, input int empty_pct);
    in_t v;
    v.dp_valid   = ($urandom_range(0, 3) != 0);
    v.rrf_alloc  = ($urandom_range(0, 5) != 0);
    v.rob_full   = ($urandom_range(0, 7) == 0);
    v.rob_empty  = ($urandom_range(0, 99) < empty_pct);
    v.req_alu    = $urandom_range(0, 1);
    v.req_mem    = $urandom_range(0, 1);
    v.alu_full   = ($urandom_range(0, 3) == 0);
    v.mem_full   = ($urandom_range(0, 3) == 0);
    v.br_resolve = ($urandom_range(0, 99) < 40);
    v.br_mis     = ($urandom_range(0, 99) < mis_pct);
    v.target     = $urandom;
    return v;
  endfunction

  task automatic drive(input logic rst, input in_t v);
    out_t e;
    @(posedge clk);
    #2;
    reset_i           = rst;
    dp_valid_i        = v.dp_valid;
    rrf_allocatable_i = v.rrf_alloc;
    rob_full_i        = v.rob_full;
    rob_empty_i       = v.rob_empty;
    dp_req_alu_i      = v.req_alu;
    dp_req_mem_i      = v.req_mem;
    rs_alu_full_i     = v.alu_full;
    rs_mem_full_i     = v.mem_full;
    br_resolve_i      = v.br_resolve;
    br_mispredict_i   = v.br_mis;
    br_target_i       = v.target;
    model_step(rst, v, e);
    exp_q.push_back(e);
  endtask

  task automatic mispredict_to(input logic [AL-1:0] tgt);
    in_t v;
    v = idle_in();
    v.br_resolve = 1'b1;
    v.br_mis     = 1'b1;
    v.target     = tgt;
    drive(1'b1, v);
  endtask

  task automatic check(input string name, input logic [AL-1:0] act, input logic [AL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // monitor: DUT presents a full output vector every cycle, sampled mid-cycle
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = out_t'(exp_q.pop_front());
        check("state",          AL'(state_o), AL'(e.state));
        check("stall",          AL'({stall_if_o, stall_id_o, stall_dp_o}), AL'(e.stall));
        check("kill",           AL'({kill_if_o, kill_id_o, kill_dp_o}), AL'(e.kill));
        check("redirect_valid", AL'(redirect_valid_o), AL'(e.redirect_valid));
        check("redirect_pc",    redirect_pc_o, e.redirect_pc);
        check("flush_backend",  AL'(flush_backend_o), AL'(e.flush));
        check("drain_timeout",  AL'(drain_timeout_o), AL'(e.timeout));
        check("stall_cycles",   AL'(stall_cycles_o), AL'(e.stall_cycles));
      end
    end
  end

  // stimulus
  initial begin
    in_t v;
    for (int i = 0; i < 3; i++) drive(1'b0, rand_in(50, 50));
    drive(1'b1, idle_in());

    // ALU RS full for three cycles
    v = idle_in();
    v.dp_valid = 1'b1; v.req_alu = 1'b1; v.alu_full = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, v);
    for (int i = 0; i < 2; i++) drive(1'b1, idle_in());

    // mispredict to 0x100, ignored second mispredict to 0x200, drain until ROB empty
    mispredict_to(32'h0000_0100);
    mispredict_to(32'h0000_0200);
    drive(1'b1, idle_in());
    v = idle_in();
    v.rob_empty = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, v);
    drive(1'b1, idle_in());
    drive(1'b1, idle_in());

    // drain timeout with ROB never emptying
    mispredict_to(32'h0000_0300);
    for (int i = 0; i < FC + DT + 4; i++) drive(1'b1, v);
    drive(1'b1, idle_in());

    // asynchronous reset in the middle of RECOVER
    mispredict_to(32'h0000_0400);
    drive(1'b0, idle_in());
    drive(1'b0, idle_in());
    drive(1'b1, idle_in());

    // stall counter saturation
    v = idle_in();
    v.dp_valid = 1'b1; v.rrf_alloc = 1'b0;
    for (int i = 0; i < (1 << PW) + 40; i++) drive(1'b1, v);
    drive(1'b1, idle_in());

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 499) != 0), rand_in(15, 30));
    end

    drive(1'b1, idle_in());
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain leftover=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
